// File: rtl/gcm_seq_ctrl.sv
// Sequencing controller for the AES-GCM core: command handshake, credit-gated input feed, output FIFO.
// Optional watchdog enabled by defining GCM_SEQ_TIMEOUT_EN.
module gcm_seq_ctrl #(
    parameter int DATA_W      = 128,
    parameter int LEN_W       = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              core_en_trig,
    output logic              core_mod,
    output logic [DATA_W-1:0] core_din,
    output logic              core_din_dv,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              core_dout_v,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = LEN_W + 1;
    localparam int OW = NW + 2;

    typedef enum logic [2:0] {IDLE, TRIG, FEED, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [NW-1:0]     issued_q, issued_d;
    logic [NW-1:0]     received_q, received_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              core_en_trig_q, core_en_trig_d;
    logic              core_mod_q, core_mod_d;
    logic [DATA_W-1:0] core_din_q, core_din_d;
    logic              core_din_dv_q, core_din_dv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic          cmd_hs, s_ready_c, s_hs, full, pop, push, overflow, stray;
    logic [NW-1:0] outstanding;
    logic [OW-1:0] occupancy;

`ifdef GCM_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_q, wd_d;
`endif

    always_comb begin
        cmd_hs      = cmd_valid && (state_q == IDLE);
        outstanding = issued_q - received_q;
        // The +1 keeps a FIFO slot free for the tag word that follows the data.
        occupancy   = OW'(count_q) + OW'(outstanding) + OW'(1);
        s_ready_c   = (state_q == FEED) && (issued_q < {1'b0, len_q}) &&
                      (occupancy < OW'(FIFO_DEPTH));
        s_hs        = s_valid && s_ready_c;
        full        = (count_q == CW'(FIFO_DEPTH));
        pop         = (count_q != '0) && m_ready;
        push        = core_dout_v && (state_q != IDLE) && (!full || pop);
        overflow    = core_dout_v && (state_q != IDLE) && full && !pop;
        stray       = core_dout_v && (state_q == IDLE);

        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d        = state_q;
        len_d          = len_q;
        issued_d       = issued_q;
        received_d     = received_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q + CW'(push) - CW'(pop);
        core_en_trig_d = 1'b0;
        core_mod_d     = core_mod_q;
        core_din_d     = core_din_q;
        core_din_dv_d  = 1'b0;
        done_d         = 1'b0;
        err_d          = err_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            received_d = received_q + NW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        unique case (state_q)
            IDLE: if (cmd_hs) begin
                len_d          = cmd_len;
                core_mod_d     = cmd_mode;
                issued_d       = '0;
                received_d     = '0;
                err_d          = 1'b0;
                core_en_trig_d = 1'b1;
                state_d        = TRIG;
            end
            TRIG: state_d = (len_q == '0) ? DRAIN : FEED;
            FEED: if (s_hs) begin
                core_din_d    = s_data;
                core_din_dv_d = 1'b1;
                issued_d      = issued_q + NW'(1);
                if (issued_q + NW'(1) == {1'b0, len_q}) state_d = DRAIN;
            end
            DRAIN: if (received_q == {1'b0, len_q} + NW'(1)) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (overflow || stray) err_d = 1'b1;

`ifdef GCM_SEQ_TIMEOUT_EN
        wd_d = '0;
        if ((state_q == FEED) || (state_q == DRAIN)) begin
            if (!(s_hs || core_dout_v)) begin
                wd_d = wd_q + WW'(1);
                if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    wd_d          = '0;
                    err_d         = 1'b1;
                    state_d       = IDLE;
                    done_d        = 1'b0;
                    core_din_dv_d = 1'b0;
                    wr_ptr_d      = '0;
                    rd_ptr_d      = '0;
                    count_d       = '0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            issued_q       <= '0;
            received_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            core_en_trig_q <= 1'b0;
            core_mod_q     <= 1'b0;
            core_din_q     <= '0;
            core_din_dv_q  <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef GCM_SEQ_TIMEOUT_EN
            wd_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            issued_q       <= issued_d;
            received_q     <= received_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            core_en_trig_q <= core_en_trig_d;
            core_mod_q     <= core_mod_d;
            core_din_q     <= core_din_d;
            core_din_dv_q  <= core_din_dv_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef GCM_SEQ_TIMEOUT_EN
            wd_q           <= wd_d;
`endif
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= core_dout;
    end

    assign cmd_ready    = (state_q == IDLE);
    assign s_ready      = s_ready_c;
    assign busy         = (state_q != IDLE);
    assign core_en_trig = core_en_trig_q;
    assign core_mod     = core_mod_q;
    assign core_din     = core_din_q;
    assign core_din_dv  = core_din_dv_q;
    assign m_data       = mem_q[rd_ptr_q];
    assign m_valid      = (count_q != '0);
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_gcm_seq_ctrl.sv
// Directed self-checking bench for gcm_seq_ctrl with a latency-3 core model and a scoreboard of popped words.
// Uses a 4-entry FIFO so credit limits are visible; the watchdog case runs only with GCM_SEQ_TIMEOUT_EN.
module tb_gcm_seq_ctrl;

    localparam int DW = 128;
    localparam int LW = 8;
    localparam logic [DW-1:0] MASK = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;
    localparam logic [DW-1:0] TAG  = 128'h7A67_7A67_0000_0000_0000_0000_CAFE_F00D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_mode = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] core_dout = '0;
    logic          core_dout_v = 1'b0;
    logic          m_ready = 1'b0;
    logic          cmd_ready, s_ready, core_en_trig, core_mod, core_din_dv;
    logic [DW-1:0] core_din, m_data;
    logic          m_valid, busy, done, err;

    gcm_seq_ctrl #(.DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .core_en_trig(core_en_trig), .core_mod(core_mod),
        .core_din(core_din), .core_din_dv(core_din_dv), .core_dout(core_dout),
        .core_dout_v(core_dout_v), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Core model: each din word comes back XOR MASK three cycles later, tag one cycle after the last.
    typedef struct { logic [DW-1:0] data; int due; } pend_t;
    pend_t pend[$];
    int    cyc = 0, mcnt = 0, cur_len = 0;
    bit    drop_tag = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (core_en_trig) begin
            mcnt = 0;
            if (cur_len == 0 && !drop_tag) pend.push_back('{TAG, cyc + 3});
        end
        if (core_din_dv) begin
            pend.push_back('{core_din ^ MASK, cyc + 3});
            mcnt++;
            if (mcnt == cur_len && !drop_tag) pend.push_back('{TAG, cyc + 4});
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            core_dout_v = 1'b1;
            core_dout   = pend[0].data;
            void'(pend.pop_front());
        end else begin
            core_dout_v = 1'b0;
        end
    end

    // Monitor of DUT outputs, sampled mid-cycle.
    logic [DW-1:0] got_q[$];
    int trig_cnt = 0, dv_cnt = 0, done_cnt = 0, bad_rdy = 0;
    logic trig_mod = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (core_en_trig) begin trig_cnt++; trig_mod = core_mod; end
            if (core_din_dv) dv_cnt++;
            if (done) done_cnt++;
            if (busy && cmd_ready) bad_rdy++;
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
    end

    // Input feeder: advances through base+idx on each accepted word.
    int feed_idx = 0, feed_n = 0;
    bit feed_en = 0;
    logic [DW-1:0] feed_base = '0;
    bit take;

    initial forever begin
        @(negedge clk);
        take = s_valid && s_ready;
        @(posedge clk);
        #2;
        if (take) feed_idx++;
        s_valid = feed_en && (feed_idx < feed_n);
        s_data  = feed_base + DW'(feed_idx);
    end

    task automatic clear_mon();
        trig_cnt = 0; dv_cnt = 0; done_cnt = 0; bad_rdy = 0;
        got_q.delete();
    endtask

    task automatic start_cmd(input logic mode, input int len, input logic [DW-1:0] base, input bit drop_valid);
        bit ok = 0;
        @(posedge clk); #1;
        cur_len = len; feed_base = base; feed_idx = 0; feed_n = len; feed_en = 1;
        cmd_mode = mode; cmd_len = LW'(len); cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_valid && cmd_ready;
        end
        if (!ok) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (drop_valid) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n_done);
        int i = 0;
        while (done_cnt < n_done && i < 500) begin @(negedge clk); i++; end
        if (done_cnt < n_done) check({tag, "_done_timeout"}, done_cnt, n_done);
    endtask

    task automatic wait_words(input string tag, input int n);
        int i = 0;
        while (got_q.size() < n && i < 500) begin @(negedge clk); i++; end
        check({tag, "_word_count"}, got_q.size(), n);
    endtask

    task automatic check_words(input string tag, input int len, input logic [DW-1:0] base);
        logic [DW-1:0] exp;
        for (int i = 0; i <= len && i < got_q.size(); i++) begin
            exp = (i == len) ? TAG : ((base + DW'(i)) ^ MASK);
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_en_trig"}, core_en_trig, 0);
        check({tag, "_core_mod"}, core_mod, 0);
        check({tag, "_core_din"}, core_din, 0);
        check({tag, "_din_dv"}, core_din_dv, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [DW-1:0] b;
        #12;
        check_reset_outputs("rst");
        @(posedge clk); #1 rst = 1'b0;

        // Encrypt, 4 words, consumer always ready.
        m_ready = 1'b1; clear_mon();
        b = 128'h1000;
        start_cmd(1'b0, 4, b, 1);
        wait_done("enc4", 1);
        wait_words("enc4", 5);
        repeat (5) @(negedge clk);
        check_words("enc4", 4, b);
        check("enc4_trig_cnt", trig_cnt, 1);
        check("enc4_mod", trig_mod, 0);
        check("enc4_dv_cnt", dv_cnt, 4);
        check("enc4_done_cnt", done_cnt, 1);
        check("enc4_err", err, 0);

        // Decrypt, tag only.
        clear_mon();
        start_cmd(1'b1, 0, '0, 1);
        wait_done("dec0", 1);
        wait_words("dec0", 1);
        repeat (5) @(negedge clk);
        check_words("dec0", 0, '0);
        check("dec0_trig_cnt", trig_cnt, 1);
        check("dec0_mod", trig_mod, 1);
        check("dec0_dv_cnt", dv_cnt, 0);
        check("dec0_done_cnt", done_cnt, 1);

        // Backpressure: credit must stop issue at 3 words with a 4-deep FIFO.
        @(posedge clk); #1 m_ready = 1'b0; clear_mon();
        b = 128'h2000;
        start_cmd(1'b0, 8, b, 1);
        repeat (30) @(negedge clk);
        check("bp_s_ready", s_ready, 0);
        check("bp_issued", feed_idx, 3);
        check("bp_m_valid", m_valid, 1);
        check("bp_err", err, 0);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_done("bp", 1);
        wait_words("bp", 9);
        check_words("bp", 8, b);
        check("bp_err_end", err, 0);

        // Second command held while busy.
        clear_mon();
        start_cmd(1'b0, 0, '0, 0);
        cmd_mode = 1'b1;
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        check("b2b_rdy_at_done", cmd_ready, 0);
        @(negedge clk);
        check("b2b_rdy_after_done", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_done("b2b", 2);
        wait_words("b2b", 2);
        check("b2b_trig_cnt", trig_cnt, 2);
        check("b2b_mod2", trig_mod, 1);
        check("b2b_busy_rdy", bad_rdy, 0);

        // Reset in the middle of FEED.
        clear_mon();
        start_cmd(1'b1, 8, 128'h3000, 1);
        for (int i = 0; i < 100 && dv_cnt < 2; i++) @(negedge clk);
        check("mid_dv_reached", dv_cnt >= 2, 1);
        @(posedge clk); #3;
        rst = 1'b1; feed_en = 0; pend.delete();
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        b = 128'h4000;
        start_cmd(1'b0, 2, b, 1);
        wait_done("post", 1);
        wait_words("post", 3);
        check_words("post", 2, b);

`ifdef GCM_SEQ_TIMEOUT_EN
        // Core never returns the tag: watchdog must abort without done.
        clear_mon(); drop_tag = 1;
        start_cmd(1'b0, 1, 128'h5000, 1);
        repeat (40) @(negedge clk);
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        check("wd_done_cnt", done_cnt, 0);
        drop_tag = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
